// File: rtl/apb_timer_pkg.sv
// Shared register map and CTRL layout for the APB multi-channel timer.
package apb_timer_pkg;

    localparam logic [4:0] OFF_LOAD   = 5'h00;
    localparam logic [4:0] OFF_VALUE  = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_INTCLR = 5'h0C;
    localparam logic [4:0] OFF_RIS    = 5'h10;
    localparam logic [4:0] OFF_MIS    = 5'h14;
    localparam logic [4:0] OFF_BGLOAD = 5'h18;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_PRE_LSB = 4;
    localparam int CTRL_PRE_MSB = 7;

    localparam logic [7:0] CH_STRIDE   = 8'h20;
    localparam logic [7:0] INTSUM_ADDR = 8'h80;
    localparam int         CH_SHIFT    = $clog2(CH_STRIDE);
    localparam int         PRESC_W     = 15;

    typedef struct packed {
        logic [3:0] pre;
        logic       oneshot;
        logic       ie;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] r;
        r = '0;
        r[CTRL_EN]      = c.en;
        r[CTRL_IE]      = c.ie;
        r[CTRL_ONESHOT] = c.oneshot;
        r[CTRL_PRE_MSB:CTRL_PRE_LSB] = c.pre;
        return r;
    endfunction

    function automatic ctrl_t ctrl_unpack(input logic [31:0] d);
        ctrl_t c;
        c.en      = d[CTRL_EN];
        c.ie      = d[CTRL_IE];
        c.oneshot = d[CTRL_ONESHOT];
        c.pre     = d[CTRL_PRE_MSB:CTRL_PRE_LSB];
        return c;
    endfunction

endpackage

// File: rtl/apb_timer_channel.sv
// One timer channel: prescaler, down-counter, raw interrupt and its control registers.
module apb_timer_channel
    import apb_timer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INTACTIVEH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_load,
    input  logic             i_wr_bgload,
    input  logic             i_wr_ctrl,
    input  logic             i_wr_intclr,
    input  logic [31:0]      i_wdata,
    output logic [WIDTH-1:0] o_load,
    output logic [WIDTH-1:0] o_value,
    output ctrl_t            o_ctrl,
    output logic             o_ris,
    output logic             o_mis,
    output logic             o_timint
);

    localparam logic IDLE_LVL = 1'(INTACTIVEH == 0);

    ctrl_t               r_ctrl;
    logic [WIDTH-1:0]    r_load;
    logic [WIDTH-1:0]    r_value;
    logic [PRESC_W-1:0]  r_presc;
    logic                r_ris;
    logic                r_timint;

    logic [PRESC_W-1:0]  w_mask;
    logic                w_tick;
    logic                w_expire;

    // Free-running prescaler: a tick whenever its low PRE bits are all ones.
    assign w_mask   = PRESC_W'((32'd1 << r_ctrl.pre) - 32'd1);
    assign w_tick   = r_ctrl.en && ((r_presc & w_mask) == w_mask);
    assign w_expire = w_tick && (r_value == '0) && !i_wr_load;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl   <= '0;
            r_load   <= '0;
            r_value  <= '0;
            r_presc  <= '0;
            r_ris    <= 1'b0;
            r_timint <= IDLE_LVL;
        end else begin
            if (i_wr_load) begin
                r_load  <= i_wdata[WIDTH-1:0];
                r_value <= i_wdata[WIDTH-1:0];
                r_presc <= '0;
            end else begin
                if (i_wr_bgload)
                    r_load <= i_wdata[WIDTH-1:0];
                r_presc <= r_ctrl.en ? r_presc + 1'b1 : '0;
                if (w_tick)
                    r_value <= (r_value == '0) ? (r_ctrl.oneshot ? '0 : r_load)
                                               : r_value - 1'b1;
            end

            // A software CTRL write overrides the one-shot self-disable.
            if (i_wr_ctrl)
                r_ctrl <= ctrl_unpack(i_wdata);
            else if (w_expire && r_ctrl.oneshot)
                r_ctrl.en <= 1'b0;

            if (w_expire)
                r_ris <= 1'b1;
            else if (i_wr_intclr)
                r_ris <= 1'b0;

            r_timint <= (r_ris & r_ctrl.ie) ^ IDLE_LVL;
        end
    end

    assign o_load   = r_load;
    assign o_value  = r_value;
    assign o_ctrl   = r_ctrl;
    assign o_ris    = r_ris;
    assign o_mis    = r_ris & r_ctrl.ie;
    assign o_timint = r_timint;

endmodule

// File: rtl/apb_multi_timer.sv
// APB slave wrapping NUM_CH timer channels: address decode, error response and read mux.
module apb_multi_timer
    import apb_timer_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 32,
    parameter int INTACTIVEH = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:2]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] TIMINT
);

    localparam int CHW = 8 - CH_SHIFT;

    logic [7:0]          w_addr;
    logic [CHW-1:0]      w_ch;
    logic [CH_SHIFT-1:0] w_off;
    logic                w_acc;
    logic                w_sum;
    logic                w_ch_ok;
    logic                w_err;
    logic                w_wr;
    logic                w_rd;
    logic [31:0]         w_rdata;

    logic [NUM_CH-1:0][WIDTH-1:0] w_load;
    logic [NUM_CH-1:0][WIDTH-1:0] w_value;
    ctrl_t [NUM_CH-1:0]           w_ctrl;
    logic [NUM_CH-1:0]            w_ris;
    logic [NUM_CH-1:0]            w_mis;

    assign w_addr  = {PADDR, 2'b00};
    assign w_ch    = w_addr[7:CH_SHIFT];
    assign w_off   = w_addr[CH_SHIFT-1:0];
    assign w_acc   = PSEL & PENABLE;
    assign w_sum   = (w_addr == INTSUM_ADDR);
    assign w_ch_ok = !w_sum && (32'(w_ch) < NUM_CH);

    // Error on missing channel, hole in the map, or access against the register's direction.
    always_comb begin
        w_err = 1'b1;
        if (w_sum)
            w_err = PWRITE;
        else if (w_ch_ok) begin
            case (w_off)
                OFF_LOAD, OFF_CTRL:           w_err = 1'b0;
                OFF_VALUE, OFF_RIS, OFF_MIS:  w_err = PWRITE;
                OFF_INTCLR, OFF_BGLOAD:       w_err = !PWRITE;
                default:                      w_err = 1'b1;
            endcase
        end
    end

    assign w_wr = w_acc & PWRITE & ~w_err;
    assign w_rd = w_acc & ~PWRITE & ~w_err & ~PRESET;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_hit;
        assign w_hit = w_wr && (32'(w_ch) == c);

        apb_timer_channel #(
            .WIDTH      (WIDTH),
            .INTACTIVEH (INTACTIVEH)
        ) u_ch (
            .i_clk       (PCLK),
            .i_rst       (PRESET),
            .i_wr_load   (w_hit && (w_off == OFF_LOAD)),
            .i_wr_bgload (w_hit && (w_off == OFF_BGLOAD)),
            .i_wr_ctrl   (w_hit && (w_off == OFF_CTRL)),
            .i_wr_intclr (w_hit && (w_off == OFF_INTCLR)),
            .i_wdata     (PWDATA),
            .o_load      (w_load[c]),
            .o_value     (w_value[c]),
            .o_ctrl      (w_ctrl[c]),
            .o_ris       (w_ris[c]),
            .o_mis       (w_mis[c]),
            .o_timint    (TIMINT[c])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_sum)
            w_rdata = 32'(w_mis);
        else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (32'(w_ch) == c) begin
                    case (w_off)
                        OFF_LOAD:  w_rdata = 32'(w_load[c]);
                        OFF_VALUE: w_rdata = 32'(w_value[c]);
                        OFF_CTRL:  w_rdata = ctrl_pack(w_ctrl[c]);
                        OFF_RIS:   w_rdata = 32'(w_ris[c]);
                        OFF_MIS:   w_rdata = 32'(w_mis[c]);
                        default:   w_rdata = '0;
                    endcase
                end
            end
        end
    end

    assign PRDATA  = w_rd ? w_rdata : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_acc & w_err;

endmodule

// File: tb/tb_apb_multi_timer.sv
// Directed + random bench for apb_multi_timer; active-high and active-low instances share one bus.
module tb_apb_multi_timer;

    localparam int          NCH   = 2;
    localparam int          W     = 16;
    localparam logic [31:0] WMASK = 32'h0000_FFFF;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:2]  PADDR = '0;
    logic [31:0] PWDATA = '0;

    logic [31:0]    prdata_h, prdata_l;
    logic           pready_h, pready_l, pslverr_h, pslverr_l;
    logic [NCH-1:0] timint_h, timint_l;

    apb_multi_timer #(.NUM_CH(NCH), .WIDTH(W), .INTACTIVEH(1)) dut_h (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_h), .PREADY(pready_h),
        .PSLVERR(pslverr_h), .TIMINT(timint_h));

    apb_multi_timer #(.NUM_CH(NCH), .WIDTH(W), .INTACTIVEH(0)) dut_l (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_l), .PREADY(pready_l),
        .PSLVERR(pslverr_l), .TIMINT(timint_l));

    always #5 PCLK = ~PCLK;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: registers as plain integers, prescaler as elapsed enabled cycles.
    int unsigned    m_load [NCH];
    int unsigned    m_val  [NCH];
    int             m_pre  [NCH];
    int             m_el   [NCH];
    bit             m_en   [NCH];
    bit             m_ie   [NCH];
    bit             m_os   [NCH];
    bit             m_ris  [NCH];
    logic [NCH-1:0] m_tim;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_load[c] = 0; m_val[c] = 0; m_pre[c] = 0; m_el[c] = 0;
            m_en[c] = 0; m_ie[c] = 0; m_os[c] = 0; m_ris[c] = 0;
        end
        m_tim = '0;
    endtask

    function automatic bit m_err(input logic [7:0] a, input bit wr);
        if (a == 8'h80) return wr;
        if (int'(a[7:5]) >= NCH) return 1'b1;
        case (a[4:0])
            5'h00, 5'h08:        return 1'b0;
            5'h04, 5'h10, 5'h14: return wr;
            5'h0C, 5'h18:        return !wr;
            default:             return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_rd(input logic [7:0] a);
        logic [31:0] r;
        int c;
        r = '0;
        if (a == 8'h80) begin
            for (int k = 0; k < NCH; k++) r[k] = m_ris[k] & m_ie[k];
            return r;
        end
        c = int'(a[7:5]);
        if (c >= NCH) return r;
        case (a[4:0])
            5'h00: r = m_load[c];
            5'h04: r = m_val[c];
            5'h08: r = 32'(m_en[c]) + 32'(m_ie[c]) * 2 + 32'(m_os[c]) * 4 + 32'(m_pre[c]) * 16;
            5'h10: r = 32'(m_ris[c]);
            5'h14: r = 32'(m_ris[c] & m_ie[c]);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance the model by one edge using the bus as currently driven, then clock and check TIMINT.
    task automatic step();
        logic [7:0]     a;
        logic [NCH-1:0] inv;
        bit             w, hit, tick, expd, en0;
        int             period;
        a = {PADDR, 2'b00};
        w = PSEL && PENABLE && PWRITE && !m_err(a, 1'b1);
        if (PRESET) m_reset();
        else for (int c = 0; c < NCH; c++) begin
            hit    = w && (int'(a[7:5]) == c);
            period = 1 << m_pre[c];
            tick   = m_en[c] && ((m_el[c] + 1) % period == 0);
            en0    = m_en[c];
            expd   = 0;
            m_tim[c] = m_ris[c] & m_ie[c];
            if (hit && a[4:0] == 5'h00) begin
                m_load[c] = PWDATA & WMASK;
                m_val[c]  = m_load[c];
                m_el[c]   = 0;
            end else begin
                if (tick) begin
                    if (m_val[c] == 0) begin
                        expd = 1;
                        if (!m_os[c]) m_val[c] = m_load[c];
                    end else m_val[c] = m_val[c] - 1;
                end
                m_el[c] = en0 ? m_el[c] + 1 : 0;
                if (hit && a[4:0] == 5'h18) m_load[c] = PWDATA & WMASK;
            end
            if (expd) begin
                m_ris[c] = 1;
                if (m_os[c]) m_en[c] = 0;
            end else if (hit && a[4:0] == 5'h0C) m_ris[c] = 0;
            if (hit && a[4:0] == 5'h08) begin
                m_en[c] = PWDATA[0]; m_ie[c] = PWDATA[1]; m_os[c] = PWDATA[2];
                m_pre[c] = int'(PWDATA[7:4]);
            end
        end
        @(posedge PCLK);
        cyc++;
        #1;
        inv = ~m_tim;
        chk("timint_h", 32'(timint_h), 32'(m_tim));
        chk("timint_l", 32'(timint_l), 32'(inv));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic apb(input logic [7:0] a, input bit wr, input logic [31:0] d,
                       input string tag, output logic [31:0] rd);
        bit          e;
        logic [31:0] ex;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a[7:2]; PWDATA = d;
        step();
        PENABLE = 1;
        #1;
        e  = m_err(a, wr);
        ex = (wr || e) ? 32'h0 : m_rd(a);
        chk({tag, "/slverr_h"}, 32'(pslverr_h), 32'(e));
        chk({tag, "/slverr_l"}, 32'(pslverr_l), 32'(e));
        chk({tag, "/prdata_h"}, prdata_h, ex);
        chk({tag, "/prdata_l"}, prdata_l, ex);
        chk({tag, "/pready"}, 32'({pready_h, pready_l}), 32'h3);
        rd = prdata_h;
        step();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb(a, 1'b1, d, "wr", dummy);
    endtask

    task automatic rd_expect(input logic [7:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        apb(a, 1'b0, 32'h0, tag, v);
        chk({tag, "/directed"}, v, exp);
    endtask

    // Wait for TIMINT_h[c] to be seen low then high; t is the edge count of the rise, -1 on timeout.
    task automatic wait_rise(input int c, input int maxc, input string tag, output int t);
        bit seen_low;
        int k;
        seen_low = 0; t = -1; k = 0;
        while (t < 0 && k < maxc) begin
            step();
            k++;
            if (!timint_h[c]) seen_low = 1;
            else if (seen_low) t = cyc;
        end
        chk({tag, "/timeout"}, 32'(t >= 0), 32'h1);
    endtask

    initial begin : main
        logic [31:0] v;
        int          t0, t1, t2, t3, k;
        logic [7:0]  a;
        logic [31:0] d;
        int          exp_seq [6] = '{2, 1, 0, 3, 2, 1};
        int          exp_tim [6] = '{0, 0, 0, 0, 1, 1};

        m_reset();
        idle(3);
        PRESET = 0;
        rd_expect(8'h00, 0, "rst_load");
        rd_expect(8'h04, 0, "rst_value");
        rd_expect(8'h08, 0, "rst_ctrl");
        rd_expect(8'h30, 0, "rst_ris1");

        // Writes are truncated to the counter width.
        wr(8'h00, 32'hABCD_1234);
        rd_expect(8'h00, 32'h1234, "trunc_load");
        rd_expect(8'h04, 32'h1234, "trunc_value");

        // Periodic: LOAD=3, PRE=0 -> 3,2,1,0,3 ...; hold the read access phase to see every cycle.
        wr(8'h00, 3);
        wr(8'h08, 32'h3);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 6'h01;
        step();
        PENABLE = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("periodic_value", prdata_h, exp_seq[i]);
            chk("periodic_model", prdata_h, m_rd(8'h04));
            chk("periodic_timint", 32'(timint_h[0]), exp_tim[i]);
            step();
        end
        PSEL = 0; PENABLE = 0;
        wr(8'h08, 0);
        wr(8'h0C, 0);

        // One-shot: LOAD=2, PRE=2 -> RIS 12 cycles after enable, TIMINT one later.
        wr(8'h20, 2);
        wr(8'h28, 32'h27);
        t0 = cyc;
        wait_rise(1, 40, "oneshot", t1);
        chk("oneshot_delay", t1 - t0, 13);
        rd_expect(8'h28, 32'h26, "oneshot_ctrl");
        rd_expect(8'h24, 0, "oneshot_value");
        idle(20);
        rd_expect(8'h24, 0, "oneshot_hold");
        wr(8'h2C, 0);

        // BGLOAD mid-count: the running period stays 10, the next is 5.
        wr(8'h00, 9);
        wr(8'h08, 32'h3);
        wait_rise(0, 40, "bg1", t1);
        wr(8'h0C, 0);
        wr(8'h18, 4);
        rd_expect(8'h00, 4, "bg_load");
        wait_rise(0, 40, "bg2", t2);
        wr(8'h0C, 0);
        wait_rise(0, 40, "bg3", t3);
        chk("bg_period1", t2 - t1, 10);
        chk("bg_period2", t3 - t2, 5);
        wr(8'h08, 0);
        wr(8'h0C, 0);

        // INTCLR landing on the expiry edge loses to the RIS set.
        wr(8'h00, 20);
        wr(8'h08, 32'h3);
        k = 0;
        while (m_val[0] != 1 && k < 100) begin step(); k++; end
        chk("collide_sync", 32'(k < 100), 32'h1);
        wr(8'h0C, 0);
        rd_expect(8'h10, 1, "collide_ris");
        wr(8'h0C, 0);
        rd_expect(8'h10, 0, "clear_ris");
        wr(8'h08, 0);

        // Unmapped channel and direction errors leave state alone.
        wr(8'h40, 32'h1234);
        rd_expect(8'h40, 0, "unmapped_rd");
        wr(8'h04, 32'h55);
        rd_expect(8'h00, 20, "unmapped_noeffect");
        rd_expect(8'h0C, 0, "wo_read");
        rd_expect(8'h84, 0, "hole_84");

        // INTSUM: only channel 1 expired with IE set.
        wr(8'h0C, 0);
        wr(8'h08, 32'h2);
        wr(8'h2C, 0);
        wr(8'h20, 1);
        wr(8'h28, 32'h7);
        wait_rise(1, 40, "sum", t1);
        rd_expect(8'h80, 32'h2, "intsum");
        wr(8'h2C, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 2) idle($urandom_range(1, 5));
            else begin
                if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h84;
                else a = 8'($urandom_range(0, 2) * 32 + $urandom_range(0, 7) * 4);
                if (a[4:0] == 5'h08)
                    d = ($urandom & 32'hFFFF_FF0F) | (32'($urandom_range(0, 2)) << 4);
                else if ($urandom_range(0, 1) != 0) d = 32'($urandom_range(0, 12));
                else d = $urandom;
                apb(a, bit'($urandom_range(0, 1)), d, "rand", v);
            end
        end

        // Reset mid-count: outputs go inactive at once, registers read back zero.
        wr(8'h00, 5);
        wr(8'h08, 32'h3);
        wr(8'h20, 7);
        wr(8'h28, 32'h3);
        idle(8);
        PRESET = 1;
        #1;
        m_reset();
        chk("rst_timint_l", 32'(timint_l), 32'h3);
        chk("rst_timint_h", 32'(timint_h), 32'h0);
        chk("rst_prdata", prdata_h, 32'h0);
        idle(2);
        PRESET = 0;
        rd_expect(8'h00, 0, "post_load0");
        rd_expect(8'h04, 0, "post_value0");
        rd_expect(8'h08, 0, "post_ctrl0");
        rd_expect(8'h24, 0, "post_value1");
        rd_expect(8'h30, 0, "post_ris1");
        idle(20);
        chk("post_quiet", 32'(timint_h), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_multi_timer.md
APB_MULTI_TIMER -- requirements
Module: apb_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..4).
REQ-002 SHALL have parameter WIDTH, default 32, counter and load width in bits (8..32).
REQ-003 SHALL have parameter INTACTIVEH, default 1, TIMINT polarity (1 = active-high, 0 = active-low).
REQ-004 SHALL have port PCLK  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PSEL  input  1  APB select.
REQ-007 SHALL have port PENABLE  input  1  APB access phase.
REQ-008 SHALL have port PWRITE  input  1  APB write (1) or read (0).
REQ-009 SHALL have port PADDR  input  [7:2]  APB word address.
REQ-010 SHALL have port PWDATA  input  32  APB write data.
REQ-011 SHALL have port PRDATA  output  32  APB read data.
REQ-012 SHALL have port PREADY  output  1  tied 1, zero wait states.
REQ-013 SHALL have port PSLVERR  output  1  error on an unmapped access.
REQ-014 SHALL have port TIMINT  output  [NUM_CH-1:0]  per-channel interrupt, registered.

Function
REQ-015 SHALL decode channel c at base c*0x20 with offsets 0x00 LOAD (RW), 0x04 VALUE (RO), 0x08 CTRL (RW), 0x0C INTCLR (WO), 0x10 RIS (RO), 0x14 MIS (RO) and 0x18 BGLOAD (WO); 0x80 INTSUM (RO) SHALL return the MIS bits of all channels in [NUM_CH-1:0].
REQ-016 SHALL define CTRL as: bit0 EN, bit1 IE, bit2 ONESHOT, bits[7:4] PRE.
REQ-017 SHALL commit writes in the cycle PSEL & PENABLE & PWRITE is high; writes SHALL be truncated to WIDTH, and reads SHALL be zero-extended.
REQ-018 SHALL drive PRDATA combinationally during the read access phase and drive 0 otherwise.
REQ-019 SHALL assert PSLVERR in the access phase for channel index >= NUM_CH, unused offsets, writes to RO registers and reads of WO registers; such writes SHALL have no effect.
REQ-020 SHALL generate a per-channel tick every 2^PRE PCLK cycles while EN=1 by means of a 15-bit prescaler; the prescaler SHALL be held at 0 while EN=0.
REQ-021 SHALL, on each tick, apply the following: if VALUE == 0, set RIS and then either reload VALUE from LOAD (ONESHOT=0) or clear EN and hold VALUE at 0 (ONESHOT=1); otherwise decrement VALUE by 1.
REQ-022 SHALL therefore give a periodic interval of (LOAD+1)*2^PRE cycles; LOAD=0 SHALL set RIS on every tick.
REQ-023 SHALL, on a LOAD write, set both LOAD and VALUE to the written data and clear the prescaler in the same edge.
REQ-024 SHALL, on a BGLOAD write, update LOAD only; VALUE and the prescaler SHALL be unaffected.
REQ-025 SHALL let a LOAD write take priority over a simultaneous tick in the same cycle.
REQ-026 SHALL let an RIS set take priority over a simultaneous INTCLR write.
REQ-027 SHALL clear RIS on any write to INTCLR.
REQ-028 SHALL compute MIS = RIS & IE.
REQ-029 SHALL drive TIMINT[c] as MIS registered one cycle, inverted when INTACTIVEH=0.
REQ-030 SHALL, on an EN 0->1 write, resume from the current VALUE without reloading.

Reset
REQ-031 SHALL, while PRESET is asserted, clear LOAD, VALUE, CTRL, RIS and the prescaler to 0 immediately.
REQ-032 SHALL, during reset, drive TIMINT to the inactive level (all 0 if INTACTIVEH=1, all 1 otherwise) and PRDATA to 0.
REQ-033 SHALL abort any count in progress when reset is asserted mid-operation; no interrupt SHALL be generated after release until software re-enables the channel.

Structure
REQ-034 SHALL place register offsets, CTRL bit positions, the channel stride (0x20) and the INTSUM address in shared package apb_timer_pkg.
REQ-035 SHALL implement one sub-module apb_timer_channel (prescaler, counter, RIS, CTRL/LOAD registers) and instantiate it NUM_CH times with a generate loop; the top level SHALL contain only the APB decode and the read mux.

Verification
REQ-036 SHALL cover periodic mode: LOAD=3, PRE=0, IE=1, EN=1 -> RIS set every 4 cycles, TIMINT pulses high 1 cycle later, VALUE sequence 3,2,1,0,3.
REQ-037 SHALL cover one-shot mode: LOAD=2, ONESHOT=1, PRE=2 -> single RIS after 12 cycles, EN reads 0 and VALUE holds 0.
REQ-038 SHALL cover BGLOAD: periodic LOAD=9, BGLOAD=4 written mid-count -> current period completes at 10 ticks and the next period is 5 ticks.
REQ-039 SHALL cover an INTCLR write landing on the same edge as an expiry -> RIS stays 1; a second INTCLR clears it.
REQ-040 SHALL cover NUM_CH=2: access to 0x40 -> PSLVERR=1 and no state change; INTSUM reads 2'b10 when only channel 1 has expired with IE=1.
REQ-041 SHALL cover PRESET asserted mid-count with INTACTIVEH=0 -> TIMINT immediately all 1 and all registers read 0.
